// File: rtl/dynaq_replay_memory.sv
// Replay memory for the Dyna-Q controller: records real (location, action) pairs,
// returns LFSR-chosen past pairs during planning, and counts planning iterations.
module dynaq_replay_memory #(
  parameter int unsigned LOC_WIDTH    = 4,
  parameter int unsigned ACTION_WIDTH = 2,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PLAN_STEPS   = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      w_history_table_enable,
  input  logic [LOC_WIDTH-1:0]      history_location,
  input  logic [ACTION_WIDTH-1:0]   history_action,
  input  logic                      random_remember_en,
  input  logic                      w_remember_time_enable,
  input  logic                      w_remember_time_select,
  output logic [LOC_WIDTH-1:0]      remember_location,
  output logic [ACTION_WIDTH-1:0]   remember_action,
  output logic                      remember_valid,
  output logic                      remember_done,
  output logic [$clog2(DEPTH):0]    history_count,
  output logic                      history_full
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned ENT_W  = LOC_WIDTH + ACTION_WIDTH;
  localparam int unsigned PROD_W = 8 + IDX_W + 1;
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [IDX_W:0] FULL_CNT  = (IDX_W + 1)'(DEPTH);
  localparam logic [7:0]     PLAN_LOAD = 8'(PLAN_STEPS);

  logic [ENT_W-1:0]        r_mem [DEPTH];
  logic [IDX_W-1:0]        r_wr_ptr;
  logic [IDX_W:0]          r_count;
  logic [15:0]             r_lfsr;
  logic [7:0]              r_plan_cnt;
  logic [LOC_WIDTH-1:0]    r_loc;
  logic [ACTION_WIDTH-1:0] r_act;
  logic                    r_valid;

  logic                    w_wr_en;
  logic                    w_smp_en;
  logic [PROD_W-1:0]       w_prod;
  logic [IDX_W:0]          w_idx;
  logic [IDX_W:0]          w_off;
  logic [IDX_W-1:0]        w_rd_ptr;
  logic [ENT_W-1:0]        w_rd_entry;
  logic [15:0]             w_lfsr_next;
  logic                    w_unused;

  // clear drops a coincident write; reset suppresses it too
  assign w_wr_en  = w_history_table_enable && !clear && !reset;
  assign w_smp_en = random_remember_en && (r_count != '0);

  // Scaled index is always < count; offset from the oldest valid entry around the ring
  assign w_prod     = PROD_W'(r_lfsr[7:0]) * PROD_W'(r_count);
  assign w_idx      = w_prod[PROD_W-1:8];
  assign w_off      = {1'b0, r_wr_ptr} - r_count + w_idx;
  assign w_rd_ptr   = w_off[IDX_W-1:0];
  assign w_rd_entry = r_mem[w_rd_ptr];
  assign w_unused   = ^{w_prod[7:0], w_off[IDX_W]};

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {history_location, history_action};
    end
  end

  // History pointer and saturating occupancy
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + IDX_W'(1);
      if (r_count != FULL_CNT) begin
        r_count <= r_count + (IDX_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Sample register; an empty history leaves the previous sample in place
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loc   <= '0;
      r_act   <= '0;
      r_valid <= 1'b0;
    end else if (w_smp_en) begin
      r_loc   <= w_rd_entry[ENT_W-1:ACTION_WIDTH];
      r_act   <= w_rd_entry[ACTION_WIDTH-1:0];
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_plan_cnt <= '0;
    end else if (w_remember_time_enable) begin
      if (!w_remember_time_select) begin
        r_plan_cnt <= PLAN_LOAD;
      end else if (r_plan_cnt != '0) begin
        r_plan_cnt <= r_plan_cnt - 8'd1;
      end
    end
  end

  assign remember_location = r_loc;
  assign remember_action   = r_act;
  assign remember_valid    = r_valid;
  assign remember_done     = (r_plan_cnt <= 8'd1);
  assign history_count     = r_count;
  assign history_full      = (r_count == FULL_CNT);

endmodule

// File: tb/tb_dynaq_replay_memory.sv
// Randomised bench for dynaq_replay_memory against a queue-based reference model.
module tb_dynaq_replay_memory;

  localparam int unsigned LW = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PLAN = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          we = 1'b0;
  logic [LW-1:0] loc = '0;
  logic [AW-1:0] act = '0;
  logic          rr = 1'b0;
  logic          te = 1'b0;
  logic          sel = 1'b0;
  logic [LW-1:0] r_loc;
  logic [AW-1:0] r_act;
  logic          r_valid;
  logic          done;
  logic [4:0]    cnt;
  logic          full;

  dynaq_replay_memory #(
    .LOC_WIDTH(LW), .ACTION_WIDTH(AW), .DEPTH(DEPTH), .PLAN_STEPS(PLAN), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .w_history_table_enable(we), .history_location(loc), .history_action(act),
    .random_remember_en(rr), .w_remember_time_enable(te), .w_remember_time_select(sel),
    .remember_location(r_loc), .remember_action(r_act), .remember_valid(r_valid),
    .remember_done(done), .history_count(cnt), .history_full(full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: history kept oldest-first in a queue
  logic [LW+AW-1:0] m_hist[$];
  logic [15:0]      m_lfsr;
  int               m_plan;
  logic [LW-1:0]    m_loc;
  logic [AW-1:0]    m_act;
  logic             m_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_hist.delete();
      m_lfsr  = 16'hACE1;
      m_plan  = 0;
      m_loc   = '0;
      m_act   = '0;
      m_valid = 1'b0;
    end else begin
      if (rr && m_hist.size() > 0) begin
        int idx;
        idx = (int'(m_lfsr[7:0]) * m_hist.size()) / 256;
        {m_loc, m_act} = m_hist[idx];
        m_valid = 1'b1;
      end
      if (clear) m_hist.delete();
      else if (we) begin
        m_hist.push_back({loc, act});
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
      end
      if (te) m_plan = sel ? ((m_plan > 0) ? m_plan - 1 : 0) : PLAN;
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(cnt), 32'(m_hist.size()));
      chk("full", 32'(full), 32'(m_hist.size() == DEPTH));
      chk("done", 32'(done), 32'(m_plan <= 1));
      chk("valid", 32'(r_valid), 32'(m_valid));
      chk("loc", 32'(r_loc), 32'(m_loc));
      chk("act", 32'(r_act), 32'(m_act));
    end
  end

  // Apply one cycle of inputs, return 2ns after the capturing edge with inputs idle
  task automatic step(input bit i_we, input logic [LW-1:0] i_loc, input logic [AW-1:0] i_act,
                      input bit i_rr, input bit i_te, input bit i_sel, input bit i_clr,
                      input bit i_rst);
    we = i_we; loc = i_loc; act = i_act; rr = i_rr;
    te = i_te; sel = i_sel; clear = i_clr; reset = i_rst;
    @(posedge clk);
    #2;
    we = 0; rr = 0; te = 0; sel = 0; clear = 0; reset = 0;
  endtask

  initial begin
    #2;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_valid", 32'(r_valid), 32'd0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("empty_sample_valid", 32'(r_valid), 32'd0);

    // Write + sample on empty history, then write + clear
    step(1, 4'h7, 2'd1, 1, 0, 0, 0, 0);
    chk("wr_smp_empty_valid", 32'(r_valid), 32'd0);
    chk("wr_smp_empty_count", 32'(cnt), 32'd1);
    step(1, 4'h9, 2'd2, 0, 0, 0, 1, 0);
    chk("wr_clr_count", 32'(cnt), 32'd0);

    step(1, 4'h5, 2'd3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("single_loc", 32'(r_loc), 32'h5);
    chk("single_act", 32'(r_act), 32'd3);
    chk("single_valid", 32'(r_valid), 32'd1);

    // Overfill, then sample heavily
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, LW'(i % 16), AW'(i % 4), 0, 0, 0, 0, 0);
    chk("sat_count", 32'(cnt), 32'd16);
    chk("sat_full", 32'(full), 32'd1);
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0);
      chk("sat_act_match", 32'(r_act), 32'(r_loc[1:0]));
    end

    // Planning counter: done seen during each decrement cycle
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      te = 1; sel = 1;
      #1;
      chk("plan_done", 32'(done), (i == 4) ? 32'd1 : 32'd0);
      step(0, 0, 0, 0, 1, 1, 0, 0);
    end
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("plan_sat", 32'(done), 32'd1);

    // Reset mid-planning with counter 3 and 7 entries
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, LW'(i), AW'(i), 0, 0, 0, 0, 0);
    chk("mid_count", 32'(cnt), 32'd7);
    chk("mid_done", 32'(done), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("mr_count", 32'(cnt), 32'd0);
    chk("mr_done", 32'(done), 32'd1);
    chk("mr_valid", 32'(r_valid), 32'd0);
    chk("mr_loc", 32'(r_loc), 32'd0);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_model_lfsr", 32'(m_lfsr), 32'hACE1);
    // Four advances from ACE1 give 1C4E; 0x4E*4>>8 = 1 picks the second write
    for (int i = 0; i < 4; i++) step(1, LW'(8 + i), AW'(i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("lfsr_restart_loc", 32'(r_loc), 32'h9);
    chk("lfsr_restart_act", 32'(r_act), 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      automatic int unsigned r = $urandom_range(0, 99);
      step(($urandom_range(0, 99) < 45), LW'($urandom), AW'($urandom),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 75), (r < 3), (r == 99));
    end

    @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
